// File: rtl/drive_cmd_sequencer.sv
// SPI-fed drive command sequencer: captures command bytes, queues them and plays
// each on the instr bus for a programmed number of PWM frames.
module drive_cmd_sequencer #(
  parameter int unsigned FRAME_CYCLES = 3072,
  parameter int unsigned DEPTH        = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  input  logic       sdi,
  input  logic       cs_n,
  output logic [1:0] instr,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned FW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
  localparam logic [1:0]    INSTR_STOP = 2'b11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [2:0]    sck_sync;
  logic [1:0]    sdi_sync;
  logic [1:0]    cs_sync;
  logic          sck_rise;
  logic [7:0]    shift_reg;
  logic [2:0]    bit_cnt;
  logic          byte_valid;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_empty;
  logic          flush_req;
  logic          push_req;
  logic          push;
  logic          pop;
  logic [7:0]    head;

  logic [0:0]    state;
  logic [5:0]    cur_dur;
  logic [FW-1:0] frame_cnt;

  // Synchronizers; cs_n resets to the deselected level so no bits are taken early.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync <= '0;
      sdi_sync <= '0;
      cs_sync  <= '1;
    end else begin
      sck_sync <= {sck_sync[1:0], sck};
      sdi_sync <= {sdi_sync[0], sdi};
      cs_sync  <= {cs_sync[0], cs_n};
    end
  end

  assign sck_rise = sck_sync[1] & ~sck_sync[2];

  // shift_reg holds the completed byte during the byte_valid cycle; the minimum sck
  // period guarantees it is not shifted again before it has been consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (cs_sync[1]) begin
        bit_cnt <= '0;
      end else if (sck_rise) begin
        shift_reg <= {shift_reg[6:0], sdi_sync[1]};
        bit_cnt   <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_valid <= 1'b1;
        end
      end
    end
  end

  assign flush_req  = byte_valid & (shift_reg[7:6] == 2'b00);
  assign push_req   = byte_valid & ~flush_req;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == COUNT_FULL);
  assign head       = mem[rd_ptr];

  always_comb begin
    pop = 1'b0;
    if (!flush_req && !fifo_empty) begin
      if (state == ST_IDLE) begin
        pop = 1'b1;
      end else if (cur_dur == '0) begin
        pop = 1'b1;
      end else if (frame_cnt == FRAME_LAST && cur_dur == 6'd1) begin
        pop = 1'b1;
      end
    end
  end

  assign push = push_req & (~fifo_full | pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= shift_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush_req) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push_req && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // A pop always reloads the executor, which covers both IDLE start and the
  // gapless hand-over at expiry or out of an indefinite hold.
  always_ff @(posedge clk) begin
    if (reset || flush_req) begin
      state     <= ST_IDLE;
      instr     <= INSTR_STOP;
      busy      <= 1'b0;
      cur_dur   <= '0;
      frame_cnt <= '0;
    end else if (pop) begin
      state     <= ST_RUN;
      instr     <= head[7:6];
      busy      <= 1'b1;
      cur_dur   <= head[5:0];
      frame_cnt <= '0;
    end else if (state == ST_RUN && cur_dur != '0) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt <= '0;
        cur_dur   <= cur_dur - 6'd1;
        if (cur_dur == 6'd1) begin
          state <= ST_IDLE;
          instr <= INSTR_STOP;
          busy  <= 1'b0;
        end
      end else begin
        frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end

endmodule

// File: tb/tb_drive_cmd_sequencer.sv
// Scoreboard bench for drive_cmd_sequencer: expected instr segments (value, length)
// are queued as commands are sent and compared as the instr bus changes.
module tb_drive_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sck = 1'b0;
  logic       sdi = 1'b0;
  logic       cs_n = 1'b1;
  logic [1:0] instr;
  logic       busy;
  logic       fifo_full;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0] v;
    int         len;   // 0: length not checked
  } seg_t;

  seg_t       sb[$];
  logic       mon_en = 1'b0;
  logic [1:0] prev_instr = 2'b11;
  int         run_len = 0;

  drive_cmd_sequencer #(.FRAME_CYCLES(16), .DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .sck      (sck),
    .sdi      (sdi),
    .cs_n     (cs_n),
    .instr    (instr),
    .busy     (busy),
    .fifo_full(fifo_full),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic expect_seg(input logic [1:0] v, input int len);
    seg_t s;
    s.v = v;
    s.len = len;
    sb.push_back(s);
  endtask

  // Segment monitor: closes a segment whenever instr changes.
  always @(negedge clk) begin
    if (mon_en) begin
      if (instr == prev_instr) begin
        run_len++;
      end else begin
        if (sb.size() == 0) begin
          check_eq("sb_extra_seg", sb.size(), 1);
        end else begin
          seg_t e;
          e = sb.pop_front();
          check_eq("seg_val", int'(prev_instr), int'(e.v));
          if (e.len != 0) check_eq("seg_len", run_len, e.len);
        end
        prev_instr = instr;
        run_len = 1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Shifts the top n bits of b MSB-first; returns just after the last sck rise.
  task automatic spi_bits(input logic [7:0] b, input int n);
    logic [7:0] v;
    v = b;
    for (int i = 0; i < n; i++) begin
      sck = 1'b0;
      sdi = v[7];
      v = {v[6:0], 1'b0};
      tick(5);
      sck = 1'b1;
      if (i != n - 1) tick(5);
    end
  endtask

  task automatic spi_byte(input logic [7:0] b);
    spi_bits(b, 8);
    tick(5);
  endtask

  task automatic cs_assert();
    cs_n = 1'b0;
    tick(3);
  endtask

  task automatic cs_release();
    tick(3);
    sck = 1'b0;
    tick(3);
    cs_n = 1'b1;
    tick(4);
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (!busy && instr == 2'b11) break;
      tick(1);
    end
    check_eq("idle_busy", int'(busy), 0);
    check_eq("idle_instr", int'(instr), 3);
  endtask

  initial begin
    int lat;
    int bc;

    tick(3);
    reset = 1'b0;
    check_eq("rst_instr", int'(instr), 3);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_full", int'(fifo_full), 0);
    check_eq("rst_ovf", int'(overflow), 0);
    prev_instr = 2'b11;
    run_len = 0;
    mon_en = 1'b1;
    expect_seg(2'b11, 0);

    // 1: single timed command, latency and busy length
    expect_seg(2'b01, 48);
    expect_seg(2'b11, 0);
    cs_assert();
    spi_bits(8'h43, 8);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (instr == 2'b01) begin
        lat = i;
        break;
      end
    end
    check_eq("t1_latency_le6", int'(lat >= 1 && lat <= 6), 1);
    bc = 1;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (!busy) break;
      bc++;
    end
    check_eq("t1_busy_len", bc, 48);
    cs_release();
    wait_idle(50);

    // 2: commands queued behind a long one play without a stop gap
    expect_seg(2'b10, 240);
    expect_seg(2'b01, 32);
    expect_seg(2'b10, 16);
    expect_seg(2'b11, 0);
    cs_assert();
    spi_byte(8'h8F);
    spi_byte(8'h42);
    spi_byte(8'h81);
    cs_release();
    wait_idle(600);

    // 3: dur=0 holds until the next command arrives
    expect_seg(2'b01, 0);
    expect_seg(2'b10, 16);
    expect_seg(2'b11, 0);
    cs_assert();
    spi_byte(8'h40);
    tick(200);
    check_eq("t3_hold", int'(instr), 1);
    check_eq("t3_hold_busy", int'(busy), 1);
    spi_byte(8'h81);
    cs_release();
    wait_idle(200);

    // 4: fill, overflow, flush
    expect_seg(2'b01, 0);
    expect_seg(2'b11, 0);
    cs_assert();
    spi_byte(8'h7F);
    for (int i = 0; i < 4; i++) spi_byte(8'hC1);
    tick(3);
    check_eq("t4_full", int'(fifo_full), 1);
    check_eq("t4_no_ovf_yet", int'(overflow), 0);
    spi_byte(8'hC1);
    tick(3);
    check_eq("t4_ovf", int'(overflow), 1);
    check_eq("t4_still_fwd", int'(instr), 1);
    spi_byte(8'h00);
    tick(2);
    check_eq("t4_flush_full", int'(fifo_full), 0);
    check_eq("t4_flush_ovf", int'(overflow), 0);
    check_eq("t4_flush_instr", int'(instr), 3);
    check_eq("t4_flush_busy", int'(busy), 0);
    cs_release();
    tick(100);
    check_eq("t4_empty_after", int'(busy), 0);

    // 5: partial byte discarded on cs_n rise
    expect_seg(2'b10, 16);
    expect_seg(2'b11, 0);
    cs_assert();
    spi_bits(8'hFF, 5);
    tick(5);
    cs_release();
    cs_assert();
    spi_byte(8'h81);
    cs_release();
    wait_idle(100);

    // 6: reset mid-run with two queued
    expect_seg(2'b10, 0);
    expect_seg(2'b11, 0);
    cs_assert();
    spi_byte(8'h8F);
    spi_byte(8'h42);
    spi_byte(8'h81);
    cs_release();
    check_eq("t6_running", int'(instr), 2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_eq("t6_rst_instr", int'(instr), 3);
    check_eq("t6_rst_busy", int'(busy), 0);
    check_eq("t6_rst_full", int'(fifo_full), 0);
    tick(400);
    check_eq("t6_no_resume_instr", int'(instr), 3);
    check_eq("t6_no_resume_busy", int'(busy), 0);

    check_eq("sb_drain", sb.size(), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
